iob_master: RTL and testbench

//  Initiator side of the IO-bus (IOB) interface: runs one 68030-style asynchronous bus cycle

---
 rtl/iob_pkg.sv | 48 ++++
 rtl/iob_master_if.sv | 49 ++++
 rtl/iob_sync.sv | 27 ++
 rtl/iob_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_iob_master.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/iob_pkg.sv
// Shared definitions for the IO-bus initiator: FSM state encoding, PORTSZ codes,
// strobe/enable bundle driven toward the motherboard, and the DSACK decode.
package iob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AS,
    ST_WAIT,
    ST_SAMPLE,
    ST_TERM,
    ST_RECOVER
  } iobState_t;

  typedef logic [1:0] portSz_t;

  localparam portSz_t PSZ_32   = 2'b00;
  localparam portSz_t PSZ_16   = 2'b01;
  localparam portSz_t PSZ_8    = 2'b10;
  localparam portSz_t PSZ_NONE = 2'b11;

  // Registered pin controls; all active-low strobes idle high
  typedef struct packed {
    logic nAoe;
    logic adLe;
    logic nAs;
    logic nDs;
    logic nDoe;
    logic ddir;
    logic dOe;
  } pinCtl_t;

  localparam pinCtl_t CTL_IDLE = '{nAoe: 1'b1, adLe: 1'b0, nAs: 1'b1, nDs: 1'b1,
                                   nDoe: 1'b1, ddir: 1'b0, dOe: 1'b0};

  // DSACK1/DSACK0 (active low, already synchronized) -> port size code
  function automatic portSz_t dsackPortsz(input logic [1:0] nDsack);
    portSz_t p;
    case (nDsack)
      2'b00:   p = PSZ_32;
      2'b01:   p = PSZ_16;  // DSACK1 only
      2'b10:   p = PSZ_8;   // DSACK0 only
      default: p = PSZ_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/iob_master_if.sv
// Request-side and IO-bus-side signals of the IOB initiator.
//  master: view of iob_master (drives bus cycle, consumes request/DSACK/BERR/data-in)
//  slave : view of the requester plus motherboard model
interface iob_master_if;
  import iob_pkg::*;

  // request side
  logic        REQ;
  logic [31:0] A;
  logic        RnW;
  logic [1:0]  SIZ;
  logic [31:0] WD;
  logic        BUSY;
  logic        ACK;
  logic [31:0] RD;
  portSz_t     PORTSZ;
  logic        ERR;
  logic        TOUT;

  // motherboard side
  logic [3:0]  IOB_A;
  logic [1:0]  IOB_SIZ;
  logic        IOB_nAOE;
  logic        IOB_ADoutLE;
  logic        IOB_nAS;
  logic        IOB_nDS;
  logic        IOB_nDOE;
  logic        IOB_DDIR;
  logic [31:0] IOB_D_OUT;
  logic        IOB_D_OE;
  logic [31:0] IOB_D_IN;
  logic [1:0]  IOB_nDSACK;
  logic        IOB_nBERR;

  modport master (
    input  REQ, A, RnW, SIZ, WD, IOB_D_IN, IOB_nDSACK, IOB_nBERR,
    output BUSY, ACK, RD, PORTSZ, ERR, TOUT,
           IOB_A, IOB_SIZ, IOB_nAOE, IOB_ADoutLE, IOB_nAS, IOB_nDS,
           IOB_nDOE, IOB_DDIR, IOB_D_OUT, IOB_D_OE
  );

  modport slave (
    output REQ, A, RnW, SIZ, WD, IOB_D_IN, IOB_nDSACK, IOB_nBERR,
    input  BUSY, ACK, RD, PORTSZ, ERR, TOUT,
           IOB_A, IOB_SIZ, IOB_nAOE, IOB_ADoutLE, IOB_nAS, IOB_nDS,
           IOB_nDOE, IOB_DDIR, IOB_D_OUT, IOB_D_OE
  );

endinterface

// File: rtl/iob_sync.sv
// Multi-bit, STAGES-deep flop synchronizer for asynchronous idle-high inputs.
//  FSBCLK, nRES : clock, async active-low reset (flops reset to all ones = deasserted)
//  d            : asynchronous inputs
//  q            : synchronized outputs
module iob_sync #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned STAGES = 2
) (
  input  logic             FSBCLK,
  input  logic             nRES,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge FSBCLK or negedge nRES) begin
    if (!nRES) begin
      stg <= '1;
    end else begin
      stg <= {stg[STAGES-2:0], d};
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/iob_master.sv
// IO-bus initiator: runs one 68030-style asynchronous bus cycle per request and
// returns read data / port size / error status with a one-cycle ACK.
//  FSBCLK, nRES         : clock, async active-low reset
//  bus.REQ/A/RnW/SIZ/WD : request, captured on accept in IDLE
//  bus.BUSY/ACK/RD/PORTSZ/ERR/TOUT : status back to the requester
//  bus.IOB_*            : motherboard strobes, address/data, DSACK/BERR inputs
// Every output is a flop; pin controls are decoded from the next state.
module iob_master
  import iob_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_DLY      = 1
) (
  input logic          FSBCLK,
  input logic          nRES,
  iob_master_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned DLY_W = (RD_DLY > 1) ? $clog2(RD_DLY + 1) : 1;

  iobState_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [DLY_W-1:0] dlyCnt, dlyNext;
  portSz_t          psLat, psNext;
  logic             errLat, errNext;
  logic             toutLat, toutNext;
  pinCtl_t          ctl, ctlNext;
  logic             busy, busyNext;
  logic             ack, ackNext;
  logic [31:0]      dOut, dOutNext;
  logic             rdLoad;

  logic             rnwLat;
  logic [31:0]      wdLat;
  logic [3:0]       iobA;
  logic [1:0]       iobSiz;
  logic [31:0]      rdQ;
  portSz_t          portSz;
  logic             errQ;
  logic             toutQ;

  logic [2:0]       syncOut;
  logic [1:0]       nDsackS;
  logic             nBerrS;
  logic             dsackHit;
  logic             berrHit;
  logic             timeoutHit;
  logic             accept;

  iob_sync #(.WIDTH(3), .STAGES(SYNC_STAGES)) u_sync (
    .FSBCLK (FSBCLK),
    .nRES   (nRES),
    .d      ({bus.IOB_nBERR, bus.IOB_nDSACK}),
    .q      (syncOut)
  );

  assign nDsackS    = syncOut[1:0];
  assign nBerrS     = syncOut[2];
  assign dsackHit   = (nDsackS != 2'b11);
  assign berrHit    = !nBerrS;
  assign timeoutHit = (cnt == CNT_W'(TIMEOUT - 1));
  assign accept     = (state == ST_IDLE) && bus.REQ;

  // State, counters and all pin/status flops
  always_ff @(posedge FSBCLK or negedge nRES) begin
    if (!nRES) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dlyCnt  <= '0;
      psLat   <= PSZ_NONE;
      errLat  <= 1'b0;
      toutLat <= 1'b0;
      ctl     <= CTL_IDLE;
      busy    <= 1'b0;
      ack     <= 1'b0;
      dOut    <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      dlyCnt  <= dlyNext;
      psLat   <= psNext;
      errLat  <= errNext;
      toutLat <= toutNext;
      ctl     <= ctlNext;
      busy    <= busyNext;
      ack     <= ackNext;
      dOut    <= dOutNext;
    end
  end

  // Next state, termination status and next pin values
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    dlyNext   = dlyCnt;
    psNext    = psLat;
    errNext   = errLat;
    toutNext  = toutLat;
    rdLoad    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.REQ) begin
          stateNext = ST_ADDR;
          cntNext   = '0;
        end
      end
      ST_ADDR: stateNext = ST_AS;
      ST_AS:   stateNext = ST_WAIT;
      ST_WAIT: begin
        cntNext = cnt + 1'b1;
        if (berrHit) begin
          // BERR wins even when DSACK arrives on the same edge
          stateNext = ST_TERM;
          psNext    = PSZ_NONE;
          errNext   = 1'b1;
          toutNext  = 1'b0;
        end else if (dsackHit) begin
          // port size frozen here; DSACK wiggles during SAMPLE are ignored
          psNext   = dsackPortsz(nDsackS);
          errNext  = 1'b0;
          toutNext = 1'b0;
          if (rnwLat && (RD_DLY != 0)) begin
            stateNext = ST_SAMPLE;
            dlyNext   = DLY_W'(RD_DLY - 1);
          end else begin
            stateNext = ST_TERM;
            rdLoad    = rnwLat;
          end
        end else if (timeoutHit) begin
          stateNext = ST_TERM;
          psNext    = PSZ_NONE;
          errNext   = 1'b1;
          toutNext  = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (dlyCnt == '0) begin
          stateNext = ST_TERM;
          rdLoad    = 1'b1;
        end else begin
          dlyNext = dlyCnt - 1'b1;
        end
      end
      ST_TERM: begin
        stateNext = ST_RECOVER;
        cntNext   = '0;
      end
      ST_RECOVER: begin
        // wait for the slave to release DSACK/BERR, bounded by the timeout
        cntNext = cnt + 1'b1;
        if ((!dsackHit && nBerrS) || timeoutHit) begin
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase

    ctlNext  = CTL_IDLE;
    busyNext = 1'b1;
    ackNext  = 1'b0;
    dOutNext = dOut;

    case (stateNext)
      ST_IDLE: busyNext = 1'b0;
      ST_ADDR: begin
        ctlNext.dOe  = 1'b1;
        ctlNext.adLe = 1'b1;
        dOutNext     = bus.A;
      end
      ST_AS, ST_WAIT, ST_SAMPLE: begin
        ctlNext.nAoe = 1'b0;
        ctlNext.nAs  = 1'b0;
        ctlNext.nDoe = 1'b0;
        if (rnwLat) begin
          ctlNext.nDs = 1'b0;
        end else begin
          // write: data strobe follows AS by one cycle
          ctlNext.nDs  = (stateNext == ST_AS);
          ctlNext.dOe  = 1'b1;
          ctlNext.ddir = 1'b1;
          dOutNext     = wdLat;
        end
      end
      ST_TERM: begin
        ctlNext.nAoe = 1'b0;
        ackNext      = 1'b1;
      end
      default: ;
    endcase
  end

  // Request capture and status returned with ACK
  always_ff @(posedge FSBCLK or negedge nRES) begin
    if (!nRES) begin
      rnwLat <= 1'b1;
      wdLat  <= '0;
      iobA   <= '0;
      iobSiz <= '0;
      rdQ    <= '0;
      portSz <= PSZ_NONE;
      errQ   <= 1'b0;
      toutQ  <= 1'b0;
    end else begin
      if (accept) begin
        rnwLat <= bus.RnW;
        wdLat  <= bus.WD;
        iobA   <= bus.A[3:0];
        iobSiz <= bus.SIZ;
      end
      if (rdLoad) begin
        rdQ <= bus.IOB_D_IN;
      end
      if (stateNext == ST_TERM) begin
        portSz <= psNext;
        errQ   <= errNext;
        toutQ  <= toutNext;
      end
    end
  end

  assign bus.BUSY        = busy;
  assign bus.ACK         = ack;
  assign bus.RD          = rdQ;
  assign bus.PORTSZ      = portSz;
  assign bus.ERR         = errQ;
  assign bus.TOUT        = toutQ;
  assign bus.IOB_A       = iobA;
  assign bus.IOB_SIZ     = iobSiz;
  assign bus.IOB_nAOE    = ctl.nAoe;
  assign bus.IOB_ADoutLE = ctl.adLe;
  assign bus.IOB_nAS     = ctl.nAs;
  assign bus.IOB_nDS     = ctl.nDs;
  assign bus.IOB_nDOE    = ctl.nDoe;
  assign bus.IOB_DDIR    = ctl.ddir;
  assign bus.IOB_D_OUT   = dOut;
  assign bus.IOB_D_OE    = ctl.dOe;

endmodule

// File: tb/tb_iob_master.sv
// Scoreboard bench for iob_master: directed bus cycles push expected ACK status;
// a negedge monitor pops and compares on every ACK.
module tb_iob_master;
  import iob_pkg::*;

  localparam int unsigned TMO = 16;

  logic FSBCLK = 1'b0;
  logic nRES;

  iob_master_if bus ();

  iob_master #(.TIMEOUT(TMO), .SYNC_STAGES(2), .RD_DLY(1)) dut (
    .FSBCLK (FSBCLK),
    .nRES   (nRES),
    .bus    (bus)
  );

  always #5 FSBCLK = ~FSBCLK;

  typedef struct {
    logic [31:0] rd;
    logic        chkRd;
    logic [1:0]  ps;
    logic        err;
    logic        tout;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   nCmp = 0;
  int   nBad = 0;
  int   nAck = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nCmp++;
    if (act !== want) begin
      nBad++;
      $display("FAIL %s: got 0x%08h, need 0x%08h", name, act, want);
    end
  endtask

  // monitor: every ACK must match the oldest expectation
  always @(negedge FSBCLK) begin : mon
    exp_t e;
    if (nRES === 1'b1 && bus.ACK === 1'b1) begin
      nAck++;
      if (sb.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL unexpected_ack: got ACK with empty scoreboard, need none");
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_portsz"}, 32'(bus.PORTSZ), 32'(e.ps));
        chk({e.tag, "_err"},    32'(bus.ERR),    32'(e.err));
        chk({e.tag, "_tout"},   32'(bus.TOUT),   32'(e.tout));
        if (e.chkRd) chk({e.tag, "_rd"}, bus.RD, e.rd);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge FSBCLK);
    #1;
  endtask

  // raise REQ and return at the negedge of the ADDR cycle
  task automatic issue(input logic [31:0] a, input logic rnw, input logic [1:0] siz,
                       input logic [31:0] wd);
    int i;
    tick(1);
    bus.REQ = 1'b1;
    bus.A   = a;
    bus.RnW = rnw;
    bus.SIZ = siz;
    bus.WD  = wd;
    i = 0;
    do begin
      @(negedge FSBCLK);
      i++;
    end while (bus.BUSY !== 1'b1 && i < 8);
    chk("accept", 32'(bus.BUSY), 32'd1);
  endtask

  task automatic respond(input int dly, input logic [1:0] nDsack, input logic nBerr,
                         input logic [31:0] din);
    tick(dly);
    bus.IOB_nDSACK = nDsack;
    bus.IOB_nBERR  = nBerr;
    bus.IOB_D_IN   = din;
  endtask

  task automatic waitAck(input int maxCyc, output int cyc);
    cyc = 0;
    while (bus.ACK !== 1'b1 && cyc < maxCyc) begin
      @(negedge FSBCLK);
      cyc++;
    end
    chk("ack_seen", 32'(bus.ACK === 1'b1), 32'd1);
  endtask

  // drop REQ the cycle after ACK, release the bus, wait for IDLE
  task automatic finishCycle();
    int i;
    tick(1);
    bus.REQ        = 1'b0;
    bus.IOB_nDSACK = 2'b11;
    bus.IOB_nBERR  = 1'b1;
    i = 0;
    while (bus.BUSY !== 1'b0 && i < 40) begin
      @(negedge FSBCLK);
      i++;
    end
    chk("idle", 32'(bus.BUSY), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int cyc;
    int ackBase;

    bus.REQ        = 1'b0;
    bus.A          = '0;
    bus.RnW        = 1'b1;
    bus.SIZ        = '0;
    bus.WD         = '0;
    bus.IOB_D_IN   = '0;
    bus.IOB_nDSACK = 2'b11;
    bus.IOB_nBERR  = 1'b1;
    nRES           = 1'b0;

    // reset state
    tick(3);
    @(negedge FSBCLK);
    chk("rst_ctl", 32'({bus.IOB_nAS, bus.IOB_nDS, bus.IOB_nAOE, bus.IOB_nDOE,
                        bus.IOB_ADoutLE, bus.IOB_DDIR, bus.IOB_D_OE}), 32'b1111000);
    chk("rst_stat", 32'({bus.BUSY, bus.ACK, bus.ERR, bus.TOUT}), 32'd0);
    chk("rst_rd", bus.RD, 32'd0);
    chk("rst_portsz", 32'(bus.PORTSZ), 32'd3);
    tick(1);
    nRES = 1'b1;

    // 32-bit read, DSACK=00 four cycles into the cycle
    sb.push_back('{rd: 32'hDEADBEEF, chkRd: 1'b1, ps: 2'b00, err: 1'b0, tout: 1'b0, tag: "rd32"});
    issue(32'h50F00010, 1'b1, 2'b00, 32'h0);
    chk("rd_addr_dout", bus.IOB_D_OUT, 32'h50F00010);
    chk("rd_addr_ctl", 32'({bus.IOB_ADoutLE, bus.IOB_D_OE, bus.IOB_nAS, bus.IOB_nAOE}), 32'b1111);
    chk("rd_iob_a", 32'(bus.IOB_A), 32'h0);
    @(negedge FSBCLK);
    chk("rd_as_ctl", 32'({bus.IOB_nAS, bus.IOB_nDS, bus.IOB_nAOE, bus.IOB_nDOE,
                          bus.IOB_D_OE, bus.IOB_DDIR, bus.IOB_ADoutLE}), 32'd0);
    respond(4, 2'b00, 1'b1, 32'hDEADBEEF);
    waitAck(30, cyc);
    finishCycle();

    // 8-bit write, DSACK0 only
    sb.push_back('{rd: 32'h0, chkRd: 1'b0, ps: 2'b10, err: 1'b0, tout: 1'b0, tag: "wr8"});
    issue(32'h50F00023, 1'b0, 2'b01, 32'h12345678);
    chk("wr_addr_dout", bus.IOB_D_OUT, 32'h50F00023);
    chk("wr_iob_a_siz", 32'({bus.IOB_A, bus.IOB_SIZ}), 32'({4'h3, 2'b01}));
    @(negedge FSBCLK);
    chk("wr_as_dout", bus.IOB_D_OUT, 32'h12345678);
    chk("wr_as_ctl", 32'({bus.IOB_nAS, bus.IOB_nDS, bus.IOB_DDIR, bus.IOB_D_OE, bus.IOB_nDOE}),
        32'b01110);
    @(negedge FSBCLK);
    chk("wr_wait_nds", 32'({bus.IOB_nAS, bus.IOB_nDS}), 32'b00);
    respond(1, 2'b10, 1'b1, 32'h0);
    waitAck(30, cyc);
    finishCycle();

    // BERR and DSACK on the same edge
    ackBase = nAck;
    sb.push_back('{rd: 32'h0, chkRd: 1'b0, ps: 2'b11, err: 1'b1, tout: 1'b0, tag: "berr"});
    issue(32'h50F00100, 1'b1, 2'b00, 32'h0);
    @(negedge FSBCLK);
    respond(2, 2'b00, 1'b0, 32'h11111111);
    waitAck(30, cyc);
    finishCycle();
    chk("berr_ack_count", 32'(nAck - ackBase), 32'd1);

    // no response: timeout 16 cycles after WAIT entry (ADDR + 2)
    sb.push_back('{rd: 32'h0, chkRd: 1'b0, ps: 2'b11, err: 1'b1, tout: 1'b1, tag: "tmo"});
    issue(32'h50F00200, 1'b1, 2'b10, 32'h0);
    waitAck(40, cyc);
    chk("tmo_latency", 32'(cyc), 32'd18);
    finishCycle();

    // reset during WAIT: strobes release immediately, no ACK
    ackBase = nAck;
    issue(32'h50F00300, 1'b1, 2'b00, 32'h0);
    @(negedge FSBCLK);
    @(negedge FSBCLK);
    @(negedge FSBCLK);
    chk("mid_before_rst", 32'({bus.IOB_nAS, bus.IOB_nDS}), 32'b00);
    #2 nRES = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'({bus.IOB_nAS, bus.IOB_nDS, bus.BUSY}), 32'b110);
    bus.REQ = 1'b0;
    tick(2);
    nRES = 1'b1;
    @(negedge FSBCLK);
    chk("mid_rst_status", 32'({bus.RD[3:0], bus.PORTSZ}), 32'({4'h0, 2'b11}));

    // clean cycle after reset: 16-bit write
    sb.push_back('{rd: 32'h0, chkRd: 1'b0, ps: 2'b01, err: 1'b0, tout: 1'b0, tag: "wr16"});
    issue(32'h50F00402, 1'b0, 2'b10, 32'hA5A5C3C3);
    @(negedge FSBCLK);
    chk("wr16_as_dout", bus.IOB_D_OUT, 32'hA5A5C3C3);
    respond(1, 2'b01, 1'b1, 32'h0);
    waitAck(30, cyc);
    finishCycle();
    chk("rst_no_ack", 32'(nAck - ackBase), 32'd1);

    // REQ held across ACK with DSACK stuck low: second cycle waits for release
    ackBase = nAck;
    sb.push_back('{rd: 32'hCAFEF00D, chkRd: 1'b1, ps: 2'b00, err: 1'b0, tout: 1'b0, tag: "hold1"});
    sb.push_back('{rd: 32'h0BADCAFE, chkRd: 1'b1, ps: 2'b01, err: 1'b0, tout: 1'b0, tag: "hold2"});
    issue(32'h50F00500, 1'b1, 2'b00, 32'h0);
    @(negedge FSBCLK);
    respond(1, 2'b00, 1'b1, 32'hCAFEF00D);
    waitAck(30, cyc);
    repeat (6) @(negedge FSBCLK);
    chk("hold_busy", 32'({bus.BUSY, bus.IOB_nAOE, bus.IOB_nAS}), 32'b111);
    chk("hold_one_ack", 32'(nAck - ackBase), 32'd1);
    tick(1);
    bus.IOB_nDSACK = 2'b11;
    cyc = 0;
    do begin
      @(negedge FSBCLK);
      cyc++;
    end while (bus.IOB_ADoutLE !== 1'b1 && cyc < 12);
    chk("hold_restart", 32'(bus.IOB_ADoutLE), 32'd1);
    @(negedge FSBCLK);
    respond(2, 2'b01, 1'b1, 32'h0BADCAFE);
    waitAck(30, cyc);
    finishCycle();
    chk("hold_two_acks", 32'(nAck - ackBase), 32'd2);

    repeat (4) @(negedge FSBCLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
